twiddle_feeder: RTL and testbench

TWIDDLE_FEEDER -- requirements
Module: twiddle_feeder

---
 rtl/twiddle_feeder.sv | 166 ++++++++++++++++
 tb/tb_twiddle_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_feeder.sv
// Twiddle feeder for one radix-2 DIT stage of an 8-point FFT.
// Loads a frame of 8 complex samples into a local buffer, then issues the four
// butterfly operand pairs (a, b, W) for the configured stage in order p=0..3.
module twiddle_feeder #(
  parameter int STAGE       = 0,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] inSample,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] outTop,
  output logic [63:0] outBottom,
  output logic [63:0] outTwiddle,
  output logic [1:0]  outPair,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam int SPAN    = 1 << STAGE;
  localparam int TW_STEP = 4 >> STAGE;

  // Buffer address of the upper butterfly operand for pair p.
  function automatic logic [2:0] top_addr(input logic [1:0] p);
    int t;
    t = ((int'(p) >> STAGE) * 2 * SPAN) + (int'(p) & (SPAN - 1));
    return 3'(t);
  endfunction

  // Twiddle exponent k for pair p.
  function automatic logic [1:0] tw_index(input logic [1:0] p);
    int k;
    k = (int'(p) & (SPAN - 1)) * TW_STEP;
    return 2'(k);
  endfunction

  // W8^k as {re, im} single-precision words.
  function automatic logic [63:0] twiddle_rom(input logic [1:0] k);
    logic [63:0] w;
    case (k)
      2'd0:    w = 64'h3F800000_00000000;
      2'd1:    w = 64'h3F3504F3_BF3504F3;
      2'd2:    w = 64'h00000000_BF800000;
      default: w = 64'hBF3504F3_BF3504F3;
    endcase
    return w;
  endfunction

  function automatic logic [2:0] write_addr(input logic [2:0] n);
    return BIT_REVERSE ? {n[0], n[1], n[2]} : n;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [2:0]  n_q, n_d;
  logic [1:0]  p_q, p_d;
  logic [63:0] buf_q [8];
  logic [63:0] buf_d [8];
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [1:0]  out_pair_q, out_pair_d;
  logic [63:0] out_top_q, out_top_d;
  logic [63:0] out_bottom_q, out_bottom_d;
  logic [63:0] out_twiddle_q, out_twiddle_d;
  logic        load_pair;
  logic [1:0]  load_p;

  // Next-state logic: sample capture in LOAD, pair issue with back-pressure in ISSUE.
  // Pair 0 is read from buf_d so the eighth sample is visible the same cycle it lands.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    p_d           = p_q;
    buf_d         = buf_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_pair_d    = out_pair_q;
    out_top_d     = out_top_q;
    out_bottom_d  = out_bottom_q;
    out_twiddle_d = out_twiddle_q;
    load_pair     = 1'b0;
    load_p        = 2'd0;

    if (state_q == LOAD) begin
      if (in_valid) begin
        buf_d[write_addr(n_q)] = inSample;
        n_d = n_q + 3'd1;
        if (n_q == 3'd7) begin
          state_d     = ISSUE;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          p_d         = 2'd0;
          load_pair   = 1'b1;
          load_p      = 2'd0;
        end
      end
    end else if (out_valid_q && out_ready) begin
      if (p_q == 2'd3) begin
        state_d     = LOAD;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        p_d         = 2'd0;
      end else begin
        p_d       = p_q + 2'd1;
        load_pair = 1'b1;
        load_p    = p_q + 2'd1;
      end
    end

    if (load_pair) begin
      out_pair_d    = load_p;
      out_last_d    = (load_p == 2'd3);
      out_top_d     = buf_d[top_addr(load_p)];
      out_bottom_d  = buf_d[top_addr(load_p) + 3'(SPAN)];
      out_twiddle_d = twiddle_rom(tw_index(load_p));
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOAD;
      n_q           <= 3'd0;
      p_q           <= 2'd0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_pair_q    <= 2'd0;
      out_top_q     <= 64'd0;
      out_bottom_q  <= 64'd0;
      out_twiddle_q <= 64'd0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      p_q           <= p_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_pair_q    <= out_pair_d;
      out_top_q     <= out_top_d;
      out_bottom_q  <= out_bottom_d;
      out_twiddle_q <= out_twiddle_d;
    end
  end

  // Sample buffer; contents survive reset and are simply overwritten by the next frame.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign outPair    = out_pair_q;
  assign outTop     = out_top_q;
  assign outBottom  = out_bottom_q;
  assign outTwiddle = out_twiddle_q;

endmodule

// File: tb/tb_twiddle_feeder.sv
// Bench for twiddle_feeder: three instances (stage/bit-reverse variants) share stimulus,
// a frame-level model predicts every output each cycle, and directed checks pin the model.
module tb_twiddle_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] inSample = 64'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_o [3];
  logic [63:0] top_o [3];
  logic [63:0] bot_o [3];
  logic [63:0] tw_o [3];
  logic [1:0]  pair_o [3];
  logic        valid_o [3];
  logic        last_o [3];

  int total_checks = 0;
  int passed_checks = 0;

  always #5 clk = ~clk;

  twiddle_feeder #(.STAGE(0), .BIT_REVERSE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .inSample(inSample), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .outTop(top_o[0]), .outBottom(bot_o[0]), .outTwiddle(tw_o[0]), .outPair(pair_o[0]),
    .out_valid(valid_o[0]), .out_ready(out_ready), .out_last(last_o[0]));

  twiddle_feeder #(.STAGE(2), .BIT_REVERSE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .inSample(inSample), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .outTop(top_o[1]), .outBottom(bot_o[1]), .outTwiddle(tw_o[1]), .outPair(pair_o[1]),
    .out_valid(valid_o[1]), .out_ready(out_ready), .out_last(last_o[1]));

  twiddle_feeder #(.STAGE(1), .BIT_REVERSE(1'b1)) dut2 (
    .clk(clk), .reset(reset), .inSample(inSample), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .outTop(top_o[2]), .outBottom(bot_o[2]), .outTwiddle(tw_o[2]), .outPair(pair_o[2]),
    .out_valid(valid_o[2]), .out_ready(out_ready), .out_last(last_o[2]));

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] smp(input int v);
    return {32'(v), 32'h0};
  endfunction

  // ---------------- frame-level reference model ----------------
  logic [63:0] m_frame [8];
  bit          m_load = 1'b1;
  int          m_cnt = 0;
  int          m_p = 0;
  bit          m_valid = 1'b0;
  bit          chk_en = 1'b0;
  logic [63:0] tw_tab [4] = '{64'h3F800000_00000000, 64'h3F3504F3_BF3504F3,
                              64'h00000000_BF800000, 64'hBF3504F3_BF3504F3};

  function automatic int stage_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction

  function automatic bit brev_of(input int d);
    return (d != 1);
  endfunction

  // Which sample index lives at buffer address a for instance d.
  function automatic logic [63:0] sample_at(input int d, input int a);
    int idx;
    idx = brev_of(d) ? (((a & 1) << 2) | (a & 2) | ((a >> 2) & 1)) : a;
    return m_frame[idx];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_load = 1'b1; m_cnt = 0; m_p = 0; m_valid = 1'b0; chk_en = 1'b1;
    end else if (m_load) begin
      if (in_valid) begin
        m_frame[m_cnt] = inSample;
        m_cnt++;
        if (m_cnt == 8) begin
          m_load = 1'b0; m_cnt = 0; m_p = 0; m_valid = 1'b1;
        end
      end
    end else if (out_ready) begin
      if (m_p == 3) begin
        m_load = 1'b1; m_valid = 1'b0;
      end else m_p++;
    end
  end

  // ---------------- per-cycle compare and transfer logging ----------------
  logic [63:0] log_top0 [$];
  logic [63:0] log_bot0 [$];
  logic [63:0] log_top1 [$];
  logic [63:0] log_tw1 [$];

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int d = 0; d < 3; d++) begin
        int span, top, k;
        span = 1 << stage_of(d);
        top  = (m_p / span) * 2 * span + (m_p % span);
        k    = (m_p % span) * (4 / span);
        check_output($sformatf("in_ready[%0d]", d), 64'(in_ready_o[d]), 64'(m_load));
        check_output($sformatf("out_valid[%0d]", d), 64'(valid_o[d]), 64'(m_valid));
        check_output($sformatf("out_last[%0d]", d), 64'(last_o[d]), 64'(m_valid && m_p == 3));
        if (m_valid) begin
          check_output($sformatf("pair[%0d]", d), 64'(pair_o[d]), 64'(m_p));
          check_output($sformatf("top[%0d]", d), top_o[d], sample_at(d, top));
          check_output($sformatf("bottom[%0d]", d), bot_o[d], sample_at(d, top + span));
          check_output($sformatf("twiddle[%0d]", d), tw_o[d], tw_tab[k]);
        end
      end
    end
    if (valid_o[0] && out_ready) begin
      log_top0.push_back(top_o[0]);
      log_bot0.push_back(bot_o[0]);
      log_top1.push_back(top_o[1]);
      log_tw1.push_back(tw_o[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_samples(input int base, input int count, input bit toggle, input bit hold_valid);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b1;
    bit rdy, v;
    while (idx < count && cyc < 100) begin
      in_valid = toggle ? ph : 1'b1;
      inSample = smp(base + idx);
      ph = !ph;
      @(negedge clk);
      rdy = in_ready_o[0];
      v = in_valid;
      @(posedge clk);
      if (v && rdy) idx++;
      #1;
      cyc++;
    end
    check_output("load_accepts", 64'(idx), 64'(count));
    in_valid = hold_valid;
    inSample = 64'hDEADBEEF_DEADBEEF;
  endtask

  task automatic drain_frame();
    int cyc = 0;
    bit done = 1'b0;
    out_ready = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      done = valid_o[0] && last_o[0] && out_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("drain_done", 64'(done), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic clear_logs();
    log_top0.delete(); log_bot0.delete(); log_top1.delete(); log_tw1.delete();
  endtask

  task automatic apply_stimulus();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_valid", 64'(valid_o[0]), 64'd0);
    check_output("rst_in_ready", 64'(in_ready_o[0]), 64'd1);
    check_output("rst_top", top_o[0], 64'd0);
    check_output("rst_twiddle", tw_o[1], 64'd0);
    check_output("rst_pair", 64'(pair_o[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Frame A: plain load, one-cycle latency, full-rate drain
    clear_logs();
    send_samples(0, 8, 1'b0, 1'b0);
    @(negedge clk);
    check_output("a_latency_valid", 64'(valid_o[0]), 64'd1);
    check_output("a_first_top", top_o[0], smp(0));
    drain_frame();
    @(negedge clk);
    check_output("a_in_ready_after", 64'(in_ready_o[0]), 64'd1);
    check_output("a_log_len", 64'(log_top0.size()), 64'd4);
    check_output("a_s0_top1", log_top0[1], smp(2));
    check_output("a_s0_bot1", log_bot0[1], smp(6));
    check_output("a_s0_top2", log_top0[2], smp(1));
    check_output("a_s0_bot3", log_bot0[3], smp(7));
    check_output("a_s2_top2", log_top1[2], smp(2));
    check_output("a_s2_tw1", log_tw1[1], 64'h3F3504F3_BF3504F3);
    check_output("a_s2_tw3", log_tw1[3], 64'hBF3504F3_BF3504F3);
    @(posedge clk); #1;

    // Frame B: stall at p=1 on the stage-1 instance
    send_samples(0, 8, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check_output("b_pair0", 64'(pair_o[2]), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("b_stall_pair", 64'(pair_o[2]), 64'd1);
      check_output("b_stall_top", top_o[2], smp(4));
      check_output("b_stall_tw", tw_o[2], 64'h00000000_BF800000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_output("b_rise_pair", 64'(pair_o[2]), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("b_next_pair", 64'(pair_o[2]), 64'd2);
    check_output("b_next_top", top_o[2], smp(1));
    check_output("b_next_bot", bot_o[2], smp(3));
    drain_frame();

    // Frame C: aborted after 5 samples by reset
    send_samples(50, 5, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("c_abort_valid", 64'(valid_o[0]), 64'd0);
    check_output("c_abort_in_ready", 64'(in_ready_o[0]), 64'd1);
    @(posedge clk); #1;

    // Frame D: toggling in_valid during load, in_valid held high during issue
    clear_logs();
    send_samples(100, 8, 1'b1, 1'b1);
    drain_frame();
    check_output("d_log_len", 64'(log_top0.size()), 64'd4);
    check_output("d_top0", log_top0[0], smp(100));
    check_output("d_top1", log_top0[1], smp(102));
    check_output("d_bot2", log_bot0[2], smp(105));
    check_output("d_top3", log_top0[3], smp(103));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("d_hold_pair", 64'(pair_o[0]), 64'd3);
    check_output("d_hold_top", top_o[0], smp(103));
    check_output("d_hold_tw", tw_o[1], 64'hBF3504F3_BF3504F3);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
